// File: rtl/resource_pool_manager.sv
// rtl/resource_pool_manager.sv - NUM_RES saturating resource counters with consume/refill requests and periodic regeneration
//
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_op, req_id, req_amount    0 = consume / 1 = refill, target channel, amount
//   rsp_valid                     one-cycle response strobe
//   rsp_ok, rsp_level             outcome and final target level, held until the next response
//   regen_en                      enables the periodic +1 regeneration tick
//   level                         all channel levels, channel i at [i*WIDTH +: WIDTH]
//   empty                         per-channel zero flags
module resource_pool_manager #(
    parameter int                 NUM_RES      = 3,
    parameter int                 WIDTH        = 8,
    parameter int                 ID_W         = 2,
    parameter logic [WIDTH-1:0]   INIT_LEVEL   = {WIDTH{1'b1}},
    parameter int                 REGEN_PERIOD = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_op,
    input  logic [ID_W-1:0]          req_id,
    input  logic [WIDTH-1:0]         req_amount,
    output logic                     rsp_valid,
    output logic                     rsp_ok,
    output logic [WIDTH-1:0]         rsp_level,
    input  logic                     regen_en,
    output logic [NUM_RES*WIDTH-1:0] level,
    output logic [NUM_RES-1:0]       empty
);

    localparam logic [WIDTH-1:0] MAX_LEVEL = {WIDTH{1'b1}};
    localparam int               CNT_W     = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   amt_q, amt_d;
    logic [WIDTH-1:0]   level_q [NUM_RES];
    logic [WIDTH-1:0]   level_d [NUM_RES];
    logic               rsp_ok_q, rsp_ok_d;
    logic [WIDTH-1:0]   rsp_level_q, rsp_level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               tick;
    logic               id_valid;
    logic [WIDTH-1:0]   cur_level;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   result;
    logic               result_ok;
    logic [WIDTH-1:0]   result_final;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] x);
        return (x == MAX_LEVEL) ? MAX_LEVEL : x + 1'b1;
    endfunction

    // Regeneration counter: runs 0..REGEN_PERIOD-1 while enabled, tick on the last count.
    always_comb begin
        tick  = 1'b0;
        cnt_d = '0;
        if (REGEN_PERIOD > 0 && regen_en) begin
            if (cnt_q == CNT_W'(REGEN_PERIOD - 1)) begin
                tick = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Request evaluation against the pre-tick level of the captured channel.
    always_comb begin
        id_valid  = (int'(id_q) < NUM_RES);
        cur_level = '0;
        for (int i = 0; i < NUM_RES; i++) begin
            if (id_q == ID_W'(i)) begin
                cur_level = level_q[i];
            end
        end
        sum       = {1'b0, cur_level} + {1'b0, amt_q};
        result    = cur_level;
        result_ok = 1'b0;
        if (op_q) begin
            result_ok = ~sum[WIDTH];
            result    = sum[WIDTH] ? MAX_LEVEL : sum[WIDTH-1:0];
        end else if (amt_q <= cur_level) begin
            result_ok = 1'b1;
            result    = cur_level - amt_q;
        end
        // A coincident tick lands on top of the request result.
        result_final = tick ? sat_inc(result) : result;
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        amt_d       = amt_q;
        rsp_ok_d    = rsp_ok_q;
        rsp_level_d = rsp_level_q;
        for (int i = 0; i < NUM_RES; i++) begin
            level_d[i] = tick ? sat_inc(level_q[i]) : level_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    id_d    = req_id;
                    amt_d   = req_amount;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (id_valid) begin
                    for (int i = 0; i < NUM_RES; i++) begin
                        if (id_q == ID_W'(i)) begin
                            level_d[i] = result_final;
                        end
                    end
                    rsp_ok_d    = result_ok;
                    rsp_level_d = result_final;
                end else begin
                    rsp_ok_d    = 1'b0;
                    rsp_level_d = '0;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 1'b0;
            id_q        <= '0;
            amt_q       <= '0;
            rsp_ok_q    <= 1'b0;
            rsp_level_q <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < NUM_RES; i++) begin
                level_q[i] <= INIT_LEVEL;
            end
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            amt_q       <= amt_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_level_q <= rsp_level_d;
            cnt_q       <= cnt_d;
            for (int i = 0; i < NUM_RES; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_ok    = rsp_ok_q;
    assign rsp_level = rsp_level_q;

    for (genvar g = 0; g < NUM_RES; g++) begin : g_out
        assign level[g*WIDTH +: WIDTH] = level_q[g];
        assign empty[g]                = (level_q[g] == '0);
    end

endmodule

// File: tb/tb_resource_pool_manager.sv
// tb/tb_resource_pool_manager.sv - randomized, model-checked bench for resource_pool_manager
module tb_resource_pool_manager;

    localparam int NR  = 3;
    localparam int W   = 8;
    localparam int P   = 4;
    localparam int MAX = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [1:0]    req_id;
    logic [W-1:0]  req_amount;
    logic          rsp_valid;
    logic          rsp_ok;
    logic [W-1:0]  rsp_level;
    logic          regen_en;
    logic [NR*W-1:0] level;
    logic [NR-1:0] empty;

    resource_pool_manager #(
        .NUM_RES(NR), .WIDTH(W), .ID_W(2), .INIT_LEVEL(8'hFF), .REGEN_PERIOD(P)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_id(req_id), .req_amount(req_amount),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_level(rsp_level),
        .regen_en(regen_en), .level(level), .empty(empty)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;
    bit rand_regen = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = request captured, 2 = response showing.
    int m_lvl [NR];
    int m_phase, m_op, m_id, m_amt, m_ok, m_rl, m_run;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < NR; i++) m_lvl[i] = MAX;
                m_phase = 0; m_ok = 0; m_rl = 0; m_run = 0;
            end else begin
                bit tick;
                int target, r, s;
                tick   = regen_en && (m_run % P == P - 1);
                m_run  = regen_en ? m_run + 1 : 0;
                target = -1;
                r      = 0;
                if (m_phase == 1) begin
                    if (m_id >= NR) begin
                        m_ok = 0; m_rl = 0;
                    end else begin
                        target = m_id;
                        if (m_op == 0) begin
                            if (m_amt <= m_lvl[m_id]) begin r = m_lvl[m_id] - m_amt; m_ok = 1; end
                            else begin r = m_lvl[m_id]; m_ok = 0; end
                        end else begin
                            s    = m_lvl[m_id] + m_amt;
                            r    = (s > MAX) ? MAX : s;
                            m_ok = (s <= MAX);
                        end
                    end
                    m_phase = 2;
                end else if (m_phase == 2) begin
                    m_phase = 0;
                end else if (req_valid) begin
                    m_op = req_op; m_id = req_id; m_amt = req_amount;
                    m_phase = 1;
                end
                for (int i = 0; i < NR; i++) begin
                    if (i == target) m_lvl[i] = r;
                    if (tick && m_lvl[i] < MAX) m_lvl[i] = m_lvl[i] + 1;
                end
                if (target >= 0) m_rl = m_lvl[target];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("req_ready", req_ready, m_phase == 0);
                chk("rsp_valid", rsp_valid, m_phase == 2);
                chk("rsp_ok", rsp_ok, m_ok);
                chk("rsp_level", rsp_level, m_rl);
                for (int i = 0; i < NR; i++) begin
                    chk($sformatf("level%0d", i), level[i*W +: W], m_lvl[i]);
                    chk($sformatf("empty%0d", i), empty[i], m_lvl[i] == 0);
                end
            end
        end
    end

    task automatic send(input int op, input int id, input int amt, output int ok, output int lvl);
        bit got;
        ok = -1; lvl = -1; got = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op[0]; req_id = id[1:0]; req_amount = amt[7:0];
        if (rand_regen) regen_en = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        req_valid = 1'b0; req_op = $urandom; req_id = $urandom; req_amount = $urandom;
        for (int t = 0; t < 8 && !got; t++) begin
            if (rsp_valid) begin
                got = 1'b1; ok = rsp_ok; lvl = rsp_level;
            end else begin
                @(negedge clk);
                if (rand_regen) regen_en = ($urandom_range(0, 3) != 0);
            end
        end
        if (!got) chk("rsp_timeout", 0, 1);
    endtask

    int ok, lv;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_id = '0; req_amount = '0; regen_en = 1'b0;
        @(negedge clk); @(negedge clk);
        check_en = 1'b1;
        chk("rst_level", level, 24'hFFFFFF);
        chk("rst_empty", empty, 3'b000);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        reset = 1'b0;

        send(0, 0, 100, ok, lv); chk("c0_ok", ok, 1); chk("c0_lvl", lv, 155);
        send(0, 1, 200, ok, lv); chk("c1a_ok", ok, 1); chk("c1a_lvl", lv, 55);
        send(0, 1, 200, ok, lv); chk("c1b_ok", ok, 0); chk("c1b_lvl", lv, 55);
        send(0, 1, 55, ok, lv);  chk("c1c_ok", ok, 1); chk("c1c_lvl", lv, 0);
        chk("empty1", empty, 3'b010);
        send(1, 0, 200, ok, lv); chk("r0_ok", ok, 0); chk("r0_lvl", lv, 255);
        send(1, 1, 10, ok, lv);  chk("r1_ok", ok, 1); chk("r1_lvl", lv, 10);
        send(0, 3, 1, ok, lv);   chk("bad_ok", ok, 0); chk("bad_lvl", lv, 0);
        chk("bad_levels", level, {8'd255, 8'd10, 8'd255});

        send(0, 2, 255, ok, lv); chk("drain_lvl", lv, 0);
        @(negedge clk); regen_en = 1'b1;
        repeat (8) @(negedge clk);
        regen_en = 1'b0;
        chk("regen_levels", level, {8'd2, 8'd12, 8'd255});

        @(negedge clk); regen_en = 1'b1;
        @(negedge clk);
        send(0, 2, 2, ok, lv); chk("tick_ok", ok, 1); chk("tick_lvl", lv, 1);
        regen_en = 1'b0;

        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_id = 2'd0; req_amount = 8'd5;
        @(negedge clk);
        req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            chk("abort_no_rsp", rsp_valid, 0);
            @(negedge clk);
        end
        chk("abort_levels", level, 24'hFFFFFF);

        rand_regen = 1'b1;
        for (int n = 0; n < 80; n++) begin
            int amt;
            amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 255);
            send($urandom_range(0, 1), $urandom_range(0, 3), amt, ok, lv);
        end
        rand_regen = 1'b0;
        regen_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/resource_pool_manager.md
Name: resource_pool_manager

Overview:
Parametrised successor to the fixed energy/tracer/fluid stores. Holds NUM_RES independent resource counters of WIDTH bits each. Serves consume and refill requests over a valid/ready handshake, with all-or-nothing consumption and saturating refill. An optional periodic regeneration tick adds 1 to every channel. It sits between the game/control logic and the resource registers and replaces ad-hoc adder/subtractor plus register chains.

Parameters:
NUM_RES, 3, number of resource channels (1..16)
WIDTH, 8, bits per resource counter; max level = 2^WIDTH-1
ID_W, 2, width of req_id; must satisfy 2^ID_W >= NUM_RES
INIT_LEVEL, all-ones (2^WIDTH-1), level loaded into every channel on reset
REGEN_PERIOD, 0, cycles between regeneration ticks; 0 disables regeneration

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  1  0 = consume, 1 = refill
req_id  in  ID_W  target channel
req_amount  in  WIDTH  amount to consume or refill
rsp_valid  out  1  one-cycle response strobe
rsp_ok  out  1  request fully honoured
rsp_level  out  WIDTH  target channel level after commit
regen_en  in  1  enables the regeneration counter
level  out  NUM_RES*WIDTH  all levels; channel i occupies bits [i*WIDTH +: WIDTH]
empty  out  NUM_RES  empty[i] = (level i == 0), combinational from the registers

Behaviour:
- Reset is synchronous, active-high, and has priority over everything else:
  - every level = INIT_LEVEL; FSM = IDLE; req_ready = 1; rsp_valid = 0, rsp_ok = 0, rsp_level = 0; regen counter = 0.
- FSM states:
  - IDLE (req_ready = 1): on req_valid && req_ready, capture op, id and amount, then go to EXEC.
  - EXEC (req_ready = 0): evaluate the request, write the level, register the response, then go to RESP.
  - RESP (req_ready = 0): rsp_valid = 1 for exactly this cycle, then go to IDLE.
- Latency: request accepted at edge N; level updated at edge N+1; rsp_valid high in the cycle after edge N+1. Maximum throughput is 1 request per 3 cycles.
- Request inputs are don't-care outside the accept cycle.
- rsp_ok and rsp_level hold their values until the next response.
- Consume:
  - amount <= level: level -= amount, ok = 1.
  - otherwise: level unchanged, ok = 0 (no partial consumption).
  - amount 0: ok = 1, level unchanged.
- Refill:
  - sum = level + amount computed at WIDTH+1 bits.
  - level = min(sum, 2^WIDTH-1).
  - ok = 1 if sum fits in WIDTH bits; ok = 0 if clipped. The clipped value is still written.
- Invalid id (req_id >= NUM_RES): no level changes, ok = 0, rsp_level = 0.
- Regeneration:
  - If REGEN_PERIOD > 0 and regen_en = 1, the counter counts 0..REGEN_PERIOD-1 and wraps.
  - When the count equals REGEN_PERIOD-1, a tick adds 1 to every channel, saturating at 2^WIDTH-1.
  - regen_en = 0 clears the counter to 0 and suppresses ticks.
- Tick coincident with an EXEC commit on the same channel:
  - The request is evaluated against the pre-tick level.
  - The +1 is then applied to the request result, saturating.
  - rsp_level reports this final value.
  - Other channels take the tick normally.
- Reset in EXEC or RESP abandons the request: no response strobe, levels return to INIT_LEVEL.
- No combinational path from req_* inputs to any output.

Test Plan:
- Reset -> all levels = 255, empty = 0, req_ready = 1, rsp_valid = 0.
- Consume id0 amt 100, accepted at edge N -> rsp_valid in the cycle after edge N+1 with rsp_ok = 1, rsp_level = 155; level0 = 155, others 255; req_ready low for exactly 2 cycles.
- Consume id1 amt 200 twice -> 1st: ok = 1, level 55. 2nd: ok = 0, level stays 55. Then consume amt 55 -> ok = 1, level 0, empty[1] = 1.
- Refill id0 (level 155) amt 200 -> ok = 0, level 255. Refill id1 (level 0) amt 10 -> ok = 1, level 10.
- req_id = 3 with NUM_RES = 3, consume amt 1 -> ok = 0, rsp_level = 0, no level change.
- REGEN_PERIOD = 4:
  - Drain id2 to 0, then regen_en = 1 for 8 cycles -> level2 = 2.
  - Consume id2 amt 2 committed on a tick edge -> ok = 1, rsp_level = 1.
  - Assert reset mid-EXEC -> no rsp_valid, all levels 255.
